// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage program counter.
// Branch-op encoding is also decoded by the instruction decoder.
package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_ABS  = 3'd1,
    BR_REL  = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4
  } br_op_t;

  localparam int PC_A_DEF     = 10;
  localparam int PC_D_DEF     = 4;
  localparam int PC_START_DEF = 0;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push when full or pop when empty is ignored here;
// the caller decides whether that is an error.
module ret_stack #(
  parameter int A = 10,
  parameter int D = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [A-1:0]             data_in,
  output logic [A-1:0]             top,
  output logic [$clog2(D+1)-1:0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int CW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  logic [A-1:0]  mem [D];
  logic [CW-1:0] cnt_m1;

  assign full   = (cnt == CW'(D));
  assign empty  = (cnt == '0);
  assign cnt_m1 = cnt - CW'(1);
  assign top    = empty ? '0 : mem[cnt_m1[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[cnt[IW-1:0]] <= data_in;
      cnt              <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt_m1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: start-driven runs, absolute/relative branches,
// call/return through ret_stack, stall and halt, and a level done flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int             A          = PC_A_DEF,
  parameter int             D          = PC_D_DEF,
  parameter logic [A-1:0]   START_ADDR = A'(PC_START_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   br_en,
  input  logic [2:0]             br_op,
  input  logic [A-1:0]           target,
  output logic [A-1:0]           pc,
  output logic                   running,
  output logic                   done,
  output logic                   stack_err,
  output logic [$clog2(D+1)-1:0] stack_cnt
);

  // Start protocol: start high parks the unit (running=0, done=0); the run
  // begins on the edge where start is sampled low after being high, and
  // done then stays high from halt until the next start.
  logic         start_q;
  logic         start_fall;
  logic [A-1:0] pc_inc;
  logic [A-1:0] pc_nxt;
  logic         running_nxt;
  logic         done_nxt;
  logic         err_nxt;
  logic         stk_push;
  logic         stk_pop;
  logic         stk_clear;
  logic [A-1:0] stk_top;
  logic         stk_full;
  logic         stk_empty;

  assign start_fall = start_q && !start;
  assign pc_inc     = pc + A'(1);

  always_comb begin
    pc_nxt      = pc;
    running_nxt = running;
    done_nxt    = done;
    err_nxt     = stack_err;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_clear   = 1'b0;
    if (start) begin
      running_nxt = 1'b0;
      done_nxt    = 1'b0;
    end else if (start_fall) begin
      pc_nxt      = START_ADDR;
      running_nxt = 1'b1;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      stk_clear   = 1'b1;
    end else if (!running || stall) begin
      pc_nxt = pc;
    end else if (halt) begin
      running_nxt = 1'b0;
      done_nxt    = 1'b1;
    end else if (br_en) begin
      case (br_op)
        BR_ABS:  pc_nxt = target;
        // Two's-complement add gives the signed offset modulo 2^A.
        BR_REL:  pc_nxt = pc + target;
        BR_CALL: begin
          pc_nxt = target;
          if (stk_full) err_nxt  = 1'b1;
          else          stk_push = 1'b1;
        end
        BR_RET: begin
          if (stk_empty) begin
            pc_nxt  = pc_inc;
            err_nxt = 1'b1;
          end else begin
            pc_nxt  = stk_top;
            stk_pop = 1'b1;
          end
        end
        default: pc_nxt = pc_inc;
      endcase
    end else begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q   <= 1'b0;
      pc        <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      start_q   <= start;
      pc        <= pc_nxt;
      running   <= running_nxt;
      done      <= done_nxt;
      stack_err <= err_nxt;
    end
  end

  ret_stack #(
    .A (A),
    .D (D)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .clear   (stk_clear),
    .push    (stk_push),
    .pop     (stk_pop),
    .data_in (pc_inc),
    .top     (stk_top),
    .cnt     (stack_cnt),
    .full    (stk_full),
    .empty   (stk_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (A=10/START=0 and A=8/START=16) driven in
// lockstep and checked every cycle against an integer reference model.
module tb_pc_unit;
  import pc_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, stall, halt, br_en;
  logic [2:0] br_op;
  logic [9:0] target;

  logic [9:0] pc0;
  logic       run0, done0, err0;
  logic [2:0] cnt0;
  logic [7:0] pc1;
  logic       run1, done1, err1;
  logic [2:0] cnt1;

  int tests = 0;
  int fails = 0;

  pc_unit #(.A(10), .D(4), .START_ADDR(10'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_en(br_en), .br_op(br_op), .target(target),
    .pc(pc0), .running(run0), .done(done0), .stack_err(err0), .stack_cnt(cnt0)
  );

  pc_unit #(.A(8), .D(4), .START_ADDR(8'd16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_en(br_en), .br_op(br_op), .target(target[7:0]),
    .pc(pc1), .running(run1), .done(done1), .stack_err(err1), .stack_cnt(cnt1)
  );

  // reference model
  int m_pc [2];
  bit m_run [2];
  bit m_done [2];
  bit m_err [2];
  bit m_sq;
  int stk0 [$];
  int stk1 [$];

  function automatic int width(int u);
    return (u == 0) ? 10 : 8;
  endfunction

  function automatic int saddr(int u);
    return (u == 0) ? 0 : 16;
  endfunction

  function automatic int stk_n(int u);
    return (u == 0) ? stk0.size() : stk1.size();
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pc[u] = 0; m_run[u] = 0; m_done[u] = 0; m_err[u] = 0;
    end
    m_sq = 0;
    stk0.delete();
    stk1.delete();
  endtask

  task automatic model_step(int u);
    int  m, t, off, v;
    bit  fall;
    m    = (1 << width(u)) - 1;
    t    = int'(target) & m;
    fall = m_sq && !start;
    if (start) begin
      m_run[u] = 0; m_done[u] = 0;
    end else if (fall) begin
      m_pc[u] = saddr(u); m_run[u] = 1; m_done[u] = 0; m_err[u] = 0;
      if (u == 0) stk0.delete(); else stk1.delete();
    end else if (!m_run[u] || stall) begin
      // nothing changes
    end else if (halt) begin
      m_run[u] = 0; m_done[u] = 1;
    end else if (br_en && br_op == 3'd1) begin
      m_pc[u] = t;
    end else if (br_en && br_op == 3'd2) begin
      off     = (t >= (1 << (width(u) - 1))) ? t - (1 << width(u)) : t;
      m_pc[u] = (m_pc[u] + off) & m;
    end else if (br_en && br_op == 3'd3) begin
      if (stk_n(u) < 4) begin
        if (u == 0) stk0.push_back((m_pc[u] + 1) & m);
        else        stk1.push_back((m_pc[u] + 1) & m);
      end else begin
        m_err[u] = 1;
      end
      m_pc[u] = t;
    end else if (br_en && br_op == 3'd4) begin
      if (stk_n(u) == 0) begin
        m_pc[u] = (m_pc[u] + 1) & m;
        m_err[u] = 1;
      end else begin
        v = (u == 0) ? stk0.pop_back() : stk1.pop_back();
        m_pc[u] = v;
      end
    end else begin
      m_pc[u] = (m_pc[u] + 1) & m;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc0",   32'(pc0),  32'(m_pc[0]));
    chk("run0",  32'(run0), 32'(m_run[0]));
    chk("done0", 32'(done0), 32'(m_done[0]));
    chk("err0",  32'(err0), 32'(m_err[0]));
    chk("cnt0",  32'(cnt0), 32'(stk_n(0)));
    chk("pc1",   32'(pc1),  32'(m_pc[1]));
    chk("run1",  32'(run1), 32'(m_run[1]));
    chk("done1", 32'(done1), 32'(m_done[1]));
    chk("err1",  32'(err1), 32'(m_err[1]));
    chk("cnt1",  32'(cnt1), 32'(stk_n(1)));
  endtask

  // drivers
  task automatic cycle(input bit st, input bit sl, input bit h, input bit be,
                       input int op, input int tg);
    start = st; stall = sl; halt = h; br_en = be;
    br_op = 3'(op); target = 10'(tg);
    @(posedge clk);
    model_step(0);
    model_step(1);
    m_sq = st;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_run();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  int ret_exp [4] = '{301, 201, 101, 6};

  initial begin
    reset = 1'b0; start = 0; stall = 0; halt = 0; br_en = 0;
    br_op = '0; target = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // basic run and halt
    start_run();
    chk("start_pc0", 32'(pc0), 32'd0);
    chk("start_pc1", 32'(pc1), 32'd16);
    chk("start_run0", 32'(run0), 32'd1);
    idle(3);
    chk("step_pc0", 32'(pc0), 32'd3);
    cycle(0, 0, 1, 0, 0, 0);
    chk("halt_done0", 32'(done0), 32'd1);
    chk("halt_run0", 32'(run0), 32'd0);
    idle(2);
    chk("halt_hold_pc0", 32'(pc0), 32'd3);
    chk("halt_hold_done0", 32'(done0), 32'd1);

    // relative and absolute branches, wrap-around
    start_run();
    idle(5);
    cycle(0, 0, 0, 1, BR_REL, 10'h3FE);
    chk("rel_pc0", 32'(pc0), 32'd3);
    chk("rel_pc1", 32'(pc1), 32'd19);
    cycle(0, 0, 0, 1, BR_ABS, 10'h3FF);
    chk("abs_pc0", 32'(pc0), 32'h3FF);
    idle(1);
    chk("wrap_pc0", 32'(pc0), 32'd0);
    chk("wrap_pc1", 32'(pc1), 32'd0);

    // call / return, nesting, overflow, underflow
    idle(4);
    cycle(0, 0, 0, 1, BR_CALL, 20);
    chk("call_pc0", 32'(pc0), 32'd20);
    chk("call_cnt0", 32'(cnt0), 32'd1);
    cycle(0, 0, 0, 1, BR_RET, 0);
    chk("ret_pc0", 32'(pc0), 32'd5);
    chk("ret_cnt0", 32'(cnt0), 32'd0);
    cycle(0, 0, 0, 1, BR_CALL, 100);
    cycle(0, 0, 0, 1, BR_CALL, 200);
    cycle(0, 0, 0, 1, BR_CALL, 300);
    cycle(0, 0, 0, 1, BR_CALL, 400);
    chk("nest_cnt0", 32'(cnt0), 32'd4);
    chk("nest_err0", 32'(err0), 32'd0);
    cycle(0, 0, 0, 1, BR_CALL, 500);
    chk("ovf_pc0", 32'(pc0), 32'd500);
    chk("ovf_cnt0", 32'(cnt0), 32'd4);
    chk("ovf_err0", 32'(err0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, BR_RET, 0);
      chk("lifo_pc0", 32'(pc0), 32'(ret_exp[i]));
    end
    cycle(0, 0, 0, 1, BR_RET, 0);
    chk("udf_pc0", 32'(pc0), 32'd7);
    chk("udf_err0", 32'(err0), 32'd1);
    idle(2);
    chk("err_sticky0", 32'(err0), 32'd1);
    start_run();
    chk("err_clr0", 32'(err0), 32'd0);

    // stall beats branch and halt
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, BR_ABS, 10'h055);
    chk("stall_pc0", 32'(pc0), 32'd0);
    cycle(0, 1, 1, 0, 0, 0);
    chk("stall_halt_done0", 32'(done0), 32'd0);
    cycle(0, 0, 1, 1, BR_ABS, 10'h055);
    chk("halt_again_done0", 32'(done0), 32'd1);
    chk("halt_beats_br_pc0", 32'(pc0), 32'd0);

    // asynchronous reset mid-run
    start_run();
    idle(2);
    cycle(0, 0, 0, 1, BR_CALL, 50);
    cycle(0, 0, 0, 1, BR_CALL, 60);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_pc0", 32'(pc0), 32'd0);
    chk("arst_cnt0", 32'(cnt0), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_run();
    chk("restart_pc1", 32'(pc1), 32'd16);
    chk("restart_run1", 32'(run1), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st, sl, h, be;
      st = m_run[0] ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      sl = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 29) == 0);
      be = ($urandom_range(0, 2) == 0);
      cycle(st, sl, h, be, int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor's fetch stage, the next generation of our start-driven PC. It adds relative branches, a hardware call/return stack, stall and halt handling, and a done indication that the test bench uses to step through its series of programs. It drives the instruction-memory address and takes branch/call/return requests from decode and the branch-condition logic.

## Interface
- A, 10: instruction-address width in bits; also the width of the PC and the branch target/offset.
- D, 4: return-stack depth in entries; must be at least 1.
- START_ADDR, 0: PC value loaded at program start; A bits wide.

- clk  in  1  single clock; all state changes on the posedge.
- reset  in  1  asynchronous, active-low; forces every register to its reset value.
- start  in  1  program request from the test bench; the run begins on its falling edge.
- stall  in  1  hold the PC this cycle; overrides halt and branch requests.
- halt  in  1  end of program, from decode.
- br_en  in  1  qualifies br_op this cycle.
- br_op  in  3  br_op_t: BR_ABS, BR_REL, BR_CALL, BR_RET; other encodings behave as no branch.
- target  in  A  absolute target (ABS, CALL), or two's-complement offset (REL); ignored for RET.
- pc  out  A  program counter register.
- running  out  1  a program is executing.
- done  out  1  program finished; stays high until the next start.
- stack_err  out  1  sticky flag for return-stack overflow or underflow.
- stack_cnt  out  $clog2(D+1)  number of valid stack entries.

## Operation
- start_q is a register holding the previous value of start. A start fall is start_q=1 and start=0.
- Priority, evaluated each posedge:
  1. start=1: running←0, done←0; pc holds.
  2. Start fall: pc←START_ADDR, running←1, done←0, stack emptied, stack_err←0.
  3. running=0: everything holds.
  4. stall=1: everything holds.
  5. halt=1: running←0, done←1; pc holds.
  6. br_en=1: the br_op action below.
  7. Otherwise: pc←pc+1.
- br_op actions:
  - BR_ABS: pc←target.
  - BR_REL: pc←pc+target, where target is sign-interpreted.
  - BR_CALL: push pc+1, then pc←target.
  - BR_RET: pop, then pc←popped value.
- All PC arithmetic is modulo 2^A; wrap-around is silent. Examples: 2^A−1 + 1 → 0, and pc=0 with offset −1 → 2^A−1.
- Stack overflow: a CALL with stack_cnt=D still jumps, but the push is dropped and stack_err←1. Existing entries are unchanged.
- Stack underflow: a RET with stack_cnt=0 gives pc←pc+1 and stack_err←1.
- stack_err clears only on reset or a start fall.

## Timing
- Reset values: pc=0, running=0, done=0, stack_err=0, stack_cnt=0, start_q=0.
- Asynchronous assert; the first posedge after deassert is evaluated normally.
- Every output is a register; a request sampled at edge N is visible after edge N.
- Start handshake:
  - start seen low at edge N with start_q=1 → pc=START_ADDR and running=1 after edge N.
  - The instruction at START_ADDR is presented during cycle N+1, and its requests are sampled at edge N+1.
- done is a level, not a pulse; the bench may hold start low indefinitely after done.
- Reset asserted mid-run empties the stack and clears all flags immediately, without waiting for a clock edge.
- Simultaneous events:
  - halt with br_en: halt wins.
  - stall with halt: stall wins, and halt must be re-presented.
  - start=1 while running aborts the run: done stays 0 and the stack is preserved until the start fall.

## Structure
- Package pc_pkg holds the br_op_t enum (3 bits: BR_NONE=0, BR_ABS, BR_REL, BR_CALL, BR_RET) and the default-parameter localparams. decode imports it.
- Sub-module ret_stack (parameters A, D):
  - LIFO with push, pop, data_in, top, cnt, full, empty; active-low async reset.
  - Push and pop are never asserted together.
  - A push when full or a pop when empty is ignored inside ret_stack; pc_unit raises stack_err itself.
- pc_unit holds the start edge detect, the control priority and the next-PC mux.

## Test plan
- Reset then start 1→0, no other requests: after the fall edge pc=0 and running=1; pc steps 1, 2, 3; halt at pc=3 → done=1, running=0, pc stays 3.
- BR_REL at pc=5 with target=10'h3FE (−2) → pc=3; BR_ABS to 10'h3FF, then no branch → pc=0 (wrap).
- CALL at pc=4 to 20 → pc=20, stack_cnt=1; RET → pc=5, stack_cnt=0; nested calls to depth D=4 then 4 RETs return in LIFO order.
- With D=4 full, a fifth CALL still jumps to its target, stack_cnt stays 4, stack_err=1; RET on an empty stack advances pc by 1 and stack_err stays 1 until the next start fall.
- stall held 3 cycles with br_en=1 → pc unchanged; stall with halt → no done until halt is re-presented without stall.
- reset pulsed low mid-run between edges → outputs 0 immediately; a new start fall restarts from START_ADDR (repeat with START_ADDR=16, A=8).
